// File: rtl/branch_predictor.sv
//------------------------------------------------------------------------------
// branch_predictor : direct-mapped 2-bit direction predictor with target buffer
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module branch_predictor #(
    parameter int         IDX_W    = 5,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [31:0]         pc_IF,
    output logic                predict_IF,
    output logic [31:0]         pred_target_IF,
    input  logic                record_we,
    input  logic [IDX_W-1:0]    record_pc,
    input  logic [29-IDX_W:0]   record_tag,
    input  logic                record_data,
    input  logic [31:0]         record_target
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    logic             valid  [DEPTH];
    logic [TAG_W-1:0] tag    [DEPTH];
    logic [1:0]       cnt    [DEPTH];
    logic [31:0]      target [DEPTH];

    logic [IDX_W-1:0] lookup_idx;
    logic [TAG_W-1:0] lookup_tag;
    logic             lookup_hit;
    logic             unused_pc_bits;

    logic             upd_hit;
    logic [1:0]       upd_cnt;
    logic [1:0]       cnt_inc;
    logic [1:0]       cnt_dec;

    assign lookup_idx     = pc_IF[IDX_W+1:2];
    assign lookup_tag     = pc_IF[31:IDX_W+2];
    assign unused_pc_bits = ^pc_IF[1:0];

    // Reads see the registered table only, so a same-cycle update shows up next cycle
    assign lookup_hit     = valid[lookup_idx] && (tag[lookup_idx] == lookup_tag);
    assign predict_IF     = lookup_hit && cnt[lookup_idx][1];
    assign pred_target_IF = predict_IF ? target[lookup_idx] : 32'h0;

    assign upd_hit = valid[record_pc] && (tag[record_pc] == record_tag);
    assign upd_cnt = cnt[record_pc];
    assign cnt_inc = (upd_cnt == 2'b11) ? 2'b11 : upd_cnt + 2'b01;
    assign cnt_dec = (upd_cnt == 2'b00) ? 2'b00 : upd_cnt - 2'b01;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid[i]  <= 1'b0;
                tag[i]    <= '0;
                cnt[i]    <= CNT_INIT;
                target[i] <= '0;
            end
        end else if (record_we) begin
            if (upd_hit) begin
                if (record_data) begin
                    cnt[record_pc]    <= cnt_inc;
                    target[record_pc] <= record_target;
                end else begin
                    cnt[record_pc]    <= cnt_dec;
                end
            end else if (record_data) begin
                // Taken miss allocates (replacing any alias); not-taken misses are never allocated
                valid[record_pc]  <= 1'b1;
                tag[record_pc]    <= record_tag;
                cnt[record_pc]    <= 2'b10;
                target[record_pc] <= record_target;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
//------------------------------------------------------------------------------
// tb_branch_predictor : directed table-driven bench for branch_predictor
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_branch_predictor;

    logic        clk;
    logic        rstn;
    logic [31:0] pc_IF;
    logic        predict_IF;
    logic [31:0] pred_target_IF;
    logic        record_we;
    logic [4:0]  record_pc;
    logic [24:0] record_tag;
    logic        record_data;
    logic [31:0] record_target;

    int compared   = 0;
    int mismatched = 0;

    branch_predictor #(.IDX_W(5), .CNT_INIT(2'b01)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .pc_IF          (pc_IF),
        .predict_IF     (predict_IF),
        .pred_target_IF (pred_target_IF),
        .record_we      (record_we),
        .record_pc      (record_pc),
        .record_tag     (record_tag),
        .record_data    (record_data),
        .record_target  (record_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  idx;
        logic [24:0] tag;
        logic        data;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic        exp_p;
        logic [31:0] exp_t;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] pc,
                         input logic exp_p, input logic [31:0] exp_t);
        pc_IF = pc;
        #1;
        compared++;
        if (predict_IF !== exp_p) begin
            mismatched++;
            $display("FAIL %s predict pc=%h: got %b expected %b", name, pc, predict_IF, exp_p);
        end
        compared++;
        if (pred_target_IF !== exp_t) begin
            mismatched++;
            $display("FAIL %s target pc=%h: got %h expected %h", name, pc, pred_target_IF, exp_t);
        end
    endtask

    task automatic do_record(input logic we, input logic [4:0] idx, input logic [24:0] tg,
                             input logic data, input logic [31:0] tgt);
        record_we     = we;
        record_pc     = idx;
        record_tag    = tg;
        record_data   = data;
        record_target = tgt;
        @(posedge clk);
        #1;
        record_we = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; pc_IF = 32'h40; record_we = 1'b0; record_pc = '0;
        record_tag = '0; record_data = 1'b0; record_target = '0;

        // Entry idx 5: tag 1 -> pc 0x94, tag 2 -> pc 0x114
        vecs.push_back('{1'b1, 5'd5, 25'd1, 1'b1, 32'h100, 32'h94, 1'b1, 32'h100}); // alloc cnt2
        vecs.push_back('{1'b1, 5'd5, 25'd1, 1'b1, 32'h100, 32'h94, 1'b1, 32'h100}); // 3
        vecs.push_back('{1'b1, 5'd5, 25'd1, 1'b1, 32'h100, 32'h94, 1'b1, 32'h100}); // 3 sat
        vecs.push_back('{1'b1, 5'd5, 25'd1, 1'b1, 32'h100, 32'h94, 1'b1, 32'h100}); // 3 sat
        vecs.push_back('{1'b1, 5'd5, 25'd1, 1'b0, 32'h0,   32'h94, 1'b1, 32'h100}); // 2
        vecs.push_back('{1'b1, 5'd5, 25'd1, 1'b0, 32'h0,   32'h94, 1'b0, 32'h0});   // 1
        vecs.push_back('{1'b1, 5'd5, 25'd1, 1'b0, 32'h0,   32'h94, 1'b0, 32'h0});   // 0
        vecs.push_back('{1'b1, 5'd5, 25'd1, 1'b0, 32'h0,   32'h94, 1'b0, 32'h0});   // 0 sat
        vecs.push_back('{1'b1, 5'd5, 25'd1, 1'b0, 32'h0,   32'h94, 1'b0, 32'h0});   // 0
        vecs.push_back('{1'b1, 5'd5, 25'd1, 1'b0, 32'h0,   32'h94, 1'b0, 32'h0});   // 0
        vecs.push_back('{1'b1, 5'd5, 25'd1, 1'b1, 32'h100, 32'h94, 1'b0, 32'h0});   // 1
        vecs.push_back('{1'b1, 5'd5, 25'd1, 1'b1, 32'h180, 32'h94, 1'b1, 32'h180}); // 2, new target
        vecs.push_back('{1'b0, 5'd5, 25'd7, 1'b1, 32'h999, 32'h94, 1'b1, 32'h180}); // we=0 ignored
        vecs.push_back('{1'b0, 5'd5, 25'd2, 1'b0, 32'h0,   32'h114, 1'b0, 32'h0});  // alias misses
        vecs.push_back('{1'b1, 5'd5, 25'd2, 1'b0, 32'h0,   32'h94, 1'b1, 32'h180}); // NT alias: A intact
        vecs.push_back('{1'b1, 5'd5, 25'd2, 1'b1, 32'h200, 32'h114, 1'b1, 32'h200}); // T alias replaces
        vecs.push_back('{1'b0, 5'd5, 25'd0, 1'b0, 32'h0,   32'h94, 1'b0, 32'h0});   // tag A gone
        vecs.push_back('{1'b1, 5'd9, 25'd3, 1'b0, 32'h0,   32'h1A4, 1'b0, 32'h0});  // NT miss no alloc
        vecs.push_back('{1'b1, 5'd9, 25'd3, 1'b1, 32'h300, 32'h1A4, 1'b1, 32'h300}); // T miss alloc

        #12;
        check("reset_pc40", 32'h40, 1'b0, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 32; i++) check("reset_probe", 32'(i) << 2, 1'b0, 32'h0);

        foreach (vecs[k]) begin
            @(negedge clk);
            do_record(vecs[k].we, vecs[k].idx, vecs[k].tag, vecs[k].data, vecs[k].tgt);
            check($sformatf("vec%0d", k), vecs[k].pc, vecs[k].exp_p, vecs[k].exp_t);
        end

        // Same-cycle read/write of idx 12, tag 4 (pc 0x230): old state this cycle, new next cycle
        @(negedge clk);
        record_we = 1'b1; record_pc = 5'd12; record_tag = 25'd4;
        record_data = 1'b1; record_target = 32'h400;
        check("same_cycle_before", 32'h230, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        record_we = 1'b0;
        check("same_cycle_after", 32'h230, 1'b1, 32'h400);

        // Async reset mid-cycle with three live entries (idx 5, 9, 12)
        @(negedge clk);
        #2;
        pc_IF = 32'h230;
        #1;
        rstn = 1'b0;
        check("async_rst_230", 32'h230, 1'b0, 32'h0);
        check("async_rst_114", 32'h114, 1'b0, 32'h0);
        check("async_rst_1A4", 32'h1A4, 1'b0, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_230", 32'h230, 1'b0, 32'h0);
        check("post_rst_114", 32'h114, 1'b0, 32'h0);
        check("post_rst_1A4", 32'h1A4, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
